// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The starvation limit default only takes effect when DMEM_ARB_STARVE_EN is defined.
package dmem_arb_pkg;

    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned CNT_W          = 8;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DMA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CORE      = 2'd1,
        DMA       = 2'd2,
        FORCE_DMA = 2'd3
    } arb_state_e;

endpackage

// File: rtl/dmem_arb_if.sv
// Bundle of requester, memory and debug signals around the data-memory arbiter.
// master = requesters plus dmem, slave = arbiter.
interface dmem_arb_if #(
    parameter int unsigned DWIDTH = 32
);
    import dmem_arb_pkg::*;

    logic              core_req;
    logic              core_we;
    logic [DWIDTH-1:0] core_addr;
    logic [DWIDTH-1:0] core_wdata;
    logic              core_gnt;
    logic              core_stall;
    logic              core_rvalid;
    logic [DWIDTH-1:0] core_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [DWIDTH-1:0] dma_addr;
    logic [DWIDTH-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DWIDTH-1:0] dma_rdata;

    logic              mem_we;
    logic [DWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;

    // Observation of the last-grant FSM and the starvation counter.
    arb_state_e        dbg_state;
    logic [CNT_W-1:0]  dbg_starve_cnt;

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_stall, core_rvalid, core_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  dbg_state, dbg_starve_cnt
    );

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_stall, core_rvalid, core_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output dbg_state, dbg_starve_cnt
    );

endinterface

// File: rtl/arb_starve_cnt.sv
// Counts consecutive denied DMA cycles and flags when the limit is reached.
// Only instantiated when DMEM_ARB_STARVE_EN is defined.
module arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = STARVE_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic             i_gnt,
    output logic             o_limit_hit,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || !i_req || i_gnt) begin
            r_cnt <= '0;
        end else if (r_cnt != LIMIT_C) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_limit_hit = (r_cnt == LIMIT_C);
    assign o_cnt       = r_cnt;

endmodule

// File: rtl/dmem_arb.sv
// Single-cycle data-memory arbiter between the core MEM stage and a DMA/debug port.
// Define DMEM_ARB_STARVE_EN to bound DMA starvation at STARVE_MAX denied cycles.
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input logic       clk,
    input logic       rst,
    dmem_arb_if.slave bus
);

    logic              w_core_gnt;
    logic              w_dma_gnt;
    logic              w_force;
    logic              w_sel;
    logic              w_we;
    logic [DWIDTH-1:0] w_addr;
    logic [DWIDTH-1:0] w_wdata;
    logic [CNT_W-1:0]  w_cnt;

    arb_state_e        r_state;
    logic              r_core_rvalid;
    logic              r_dma_rvalid;
    logic [DWIDTH-1:0] r_core_rdata;
    logic [DWIDTH-1:0] r_dma_rdata;

`ifdef DMEM_ARB_STARVE_EN
    arb_starve_cnt #(
        .LIMIT (STARVE_MAX)
    ) u_starve (
        .clk         (clk),
        .rst         (rst),
        .i_req       (bus.dma_req),
        .i_gnt       (w_dma_gnt),
        .o_limit_hit (w_force),
        .o_cnt       (w_cnt)
    );
`else
    assign w_force = 1'b0;
    assign w_cnt   = '0;
`endif

    // Limit must be reachable by the counter and non-zero.
    a_limit_range: assert property (@(posedge clk)
        (STARVE_MAX > 0) && (STARVE_MAX < (1 << CNT_W)));

    always_comb begin
        w_dma_gnt  = 1'b0;
        w_core_gnt = 1'b0;
        if (!rst) begin
            w_dma_gnt  = bus.dma_req & (~bus.core_req | w_force);
            w_core_gnt = bus.core_req & ~w_dma_gnt;
        end
    end

    assign w_sel   = w_dma_gnt ? REQ_DMA : REQ_CORE;
    assign w_addr  = (w_sel == REQ_DMA) ? bus.dma_addr  : bus.core_addr;
    assign w_wdata = (w_sel == REQ_DMA) ? bus.dma_wdata : bus.core_wdata;
    assign w_we    = (w_sel == REQ_DMA) ? (w_dma_gnt & bus.dma_we)
                                        : (w_core_gnt & bus.core_we);

    assign bus.mem_addr   = w_addr;
    assign bus.mem_wdata  = w_wdata;
    assign bus.mem_we     = w_we;
    assign bus.core_gnt   = w_core_gnt;
    assign bus.dma_gnt    = w_dma_gnt;
    assign bus.core_stall = bus.core_req & ~w_core_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (w_dma_gnt && w_force) begin
            r_state <= FORCE_DMA;
        end else if (w_dma_gnt) begin
            r_state <= DMA;
        end else if (w_core_gnt) begin
            r_state <= CORE;
        end else begin
            r_state <= IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_core_rvalid <= 1'b0;
            r_dma_rvalid  <= 1'b0;
            r_core_rdata  <= '0;
            r_dma_rdata   <= '0;
        end else begin
            r_core_rvalid <= w_core_gnt & ~bus.core_we;
            r_dma_rvalid  <= w_dma_gnt & ~bus.dma_we;
            if (w_core_gnt && !bus.core_we) begin
                r_core_rdata <= bus.mem_rdata;
            end
            if (w_dma_gnt && !bus.dma_we) begin
                r_dma_rdata <= bus.mem_rdata;
            end
        end
    end

    // Reset masks registered outputs immediately so an in-flight read never surfaces.
    assign bus.core_rvalid    = r_core_rvalid & ~rst;
    assign bus.dma_rvalid     = r_dma_rvalid & ~rst;
    assign bus.core_rdata     = rst ? '0 : r_core_rdata;
    assign bus.dma_rdata      = rst ? '0 : r_dma_rdata;
    assign bus.dbg_state      = rst ? IDLE : r_state;
    assign bus.dbg_starve_cnt = rst ? '0 : w_cnt;

endmodule

// File: tb/tb_dmem_arb.sv
// Scoreboard bench for dmem_arb: directed scenarios then random traffic against a queue model.
`timescale 1ns/1ps
module tb_dmem_arb;
    import dmem_arb_pkg::*;

    localparam int unsigned DW   = 32;
    localparam int unsigned SMAX = 4;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] due;
    } ret_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        preload = 1'b1;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arb_if #(.DWIDTH(DW)) bus ();

    dmem_arb #(
        .DWIDTH     (DW),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] init_val(input logic [7:0] a);
        if (a == 8'h20) return 32'h0000_1234;
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    // Environment memory: combinational read, write on the clock edge.
    logic [31:0] env_mem [256];
    assign bus.mem_rdata = env_mem[bus.mem_addr[7:0]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_val(8'(i));
        end else if (bus.mem_we === 1'b1) begin
            env_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [256];
    int unsigned m_deny = 0;
    arb_state_e  m_state = IDLE;
    ret_t        core_q[$];
    ret_t        dma_q[$];
    logic [31:0] core_last = '0;
    logic [31:0] dma_last = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic r,
                        input logic cr, input logic cw, input logic [7:0] ca,
                        input logic [31:0] cd,
                        input logic dr, input logic dw, input logic [7:0] da,
                        input logic [31:0] dd,
                        output logic o_dg, output logic o_stall);
        logic        eg_c, eg_d, forced, e_we;
        logic [31:0] e_addr, e_wd;
        arb_state_e  e_st;
        logic [7:0]  e_cnt;
        @(posedge clk);
        #1;
        rst = r;
        bus.core_req = cr; bus.core_we = cw; bus.core_addr = {24'h0, ca}; bus.core_wdata = cd;
        bus.dma_req = dr;  bus.dma_we = dw;  bus.dma_addr = {24'h0, da};  bus.dma_wdata = dd;
        e_st   = m_state;
        e_cnt  = STARVE_EN ? 8'(m_deny) : 8'h0;
        forced = 1'b0;
        eg_c   = 1'b0;
        eg_d   = 1'b0;
        if (r) begin
            e_st = IDLE;
            e_cnt = 8'h0;
            core_q.delete();
            dma_q.delete();
            core_last = '0;
            dma_last = '0;
            m_deny = 0;
            m_state = IDLE;
        end else begin
            forced = STARVE_EN && dr && (m_deny == SMAX);
            eg_d = dr && (!cr || forced);
            eg_c = cr && !eg_d;
            if (eg_c && !cw) core_q.push_back('{data: ref_mem[ca], due: cyc + 1});
            if (eg_d && !dw) dma_q.push_back('{data: ref_mem[da], due: cyc + 1});
            if (eg_c && cw) ref_mem[ca] = cd;
            if (eg_d && dw) ref_mem[da] = dd;
            if (dr && !eg_d) m_deny = (m_deny >= SMAX) ? SMAX : m_deny + 1;
            else m_deny = 0;
            m_state = forced ? FORCE_DMA : eg_d ? DMA : eg_c ? CORE : IDLE;
        end
        e_we   = (eg_c && cw) || (eg_d && dw);
        e_addr = eg_d ? {24'h0, da} : {24'h0, ca};
        e_wd   = eg_d ? dd : cd;
        @(negedge clk);
        chk("core_gnt", 64'(bus.core_gnt), 64'(eg_c));
        chk("dma_gnt", 64'(bus.dma_gnt), 64'(eg_d));
        chk("core_stall", 64'(bus.core_stall), 64'(cr && !eg_c));
        chk("mem_we", 64'(bus.mem_we), 64'(e_we));
        if (eg_c || eg_d) chk("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
        if (e_we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(e_wd));
        chk("fsm_state", 64'(bus.dbg_state), 64'(e_st));
        chk("starve_cnt", 64'(bus.dbg_starve_cnt), 64'(e_cnt));
        o_dg    = bus.dma_gnt;
        o_stall = bus.core_stall;
    endtask

    // Monitor: pops expected read returns whenever the DUT presents one.
    always @(negedge clk) begin
        ret_t e;
        if (bus.core_rvalid === 1'b1) begin
            if (core_q.size() == 0) begin
                chk("core_rvalid_spurious", 64'(1), 64'(0));
            end else begin
                e = core_q.pop_front();
                chk("core_rdata", 64'(bus.core_rdata), 64'(e.data));
                chk("core_rlat", 64'(cyc), 64'(e.due));
                core_last = e.data;
            end
        end else begin
            chk("core_rdata_hold", 64'(bus.core_rdata), 64'(core_last));
            if (core_q.size() != 0 && core_q[0].due <= cyc) begin
                chk("core_rvalid_missing", 64'(0), 64'(1));
                void'(core_q.pop_front());
            end
        end
        if (bus.dma_rvalid === 1'b1) begin
            if (dma_q.size() == 0) begin
                chk("dma_rvalid_spurious", 64'(1), 64'(0));
            end else begin
                e = dma_q.pop_front();
                chk("dma_rdata", 64'(bus.dma_rdata), 64'(e.data));
                chk("dma_rlat", 64'(cyc), 64'(e.due));
                dma_last = e.data;
            end
        end else begin
            chk("dma_rdata_hold", 64'(bus.dma_rdata), 64'(dma_last));
            if (dma_q.size() != 0 && dma_q[0].due <= cyc) begin
                chk("dma_rvalid_missing", 64'(0), 64'(1));
                void'(dma_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic       dg, st;
        logic [9:0] dg_vec, st_vec;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
        bus.dma_req = 1'b0;  bus.dma_we = 1'b0;  bus.dma_addr = '0;  bus.dma_wdata = '0;
        @(posedge clk);
        #1 preload = 1'b0;

        for (int i = 0; i < 3; i++) step(1, 1, 0, 8'h10, 0, 1, 0, 8'h20, 0, dg, st);

        // Core write then read back
        step(0, 1, 1, 8'h10, 32'hDEAD_BEEF, 0, 0, 8'h00, 0, dg, st);
        step(0, 1, 0, 8'h10, 0, 0, 0, 8'h00, 0, dg, st);
        step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, dg, st);
        chk("core_readback", 64'(bus.core_rdata), 64'h0000_0000_DEAD_BEEF);

        // DMA read of preloaded word
        step(0, 0, 0, 8'h00, 0, 1, 0, 8'h20, 0, dg, st);
        step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, dg, st);
        chk("dma_preload_read", 64'(bus.dma_rdata), 64'h0000_0000_0000_1234);

        // Ten cycles of contention
        dg_vec = '0;
        st_vec = '0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 8'h10, 0, 1, 0, 8'h20, 0, dg, st);
            dg_vec[i] = dg;
            st_vec[i] = st;
        end
        chk("contention_dma_gnt", 64'(dg_vec), STARVE_EN ? 64'h210 : 64'h0);
        chk("contention_stall", 64'(st_vec), STARVE_EN ? 64'h210 : 64'h0);

        // Reset lands on a core read in flight with a non-zero starvation count
        step(0, 1, 0, 8'h10, 0, 1, 0, 8'h20, 0, dg, st);
        step(0, 1, 0, 8'h10, 0, 1, 0, 8'h20, 0, dg, st);
        step(1, 1, 0, 8'h10, 0, 1, 0, 8'h20, 0, dg, st);
        chk("rst_mid_read_rvalid", 64'(bus.core_rvalid), 64'(0));
        step(0, 0, 0, 8'h00, 0, 1, 0, 8'h20, 0, dg, st);
        chk("post_rst_first_gnt", 64'(dg), 64'(1));

        // Back-to-back core write then DMA read of the same word
        step(0, 1, 1, 8'h40, 32'hCAFE_0040, 0, 0, 8'h00, 0, dg, st);
        step(0, 0, 0, 8'h00, 0, 1, 0, 8'h40, 0, dg, st);
        step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, dg, st);
        chk("b2b_dma_rdata", 64'(bus.dma_rdata), 64'h0000_0000_CAFE_0040);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) < 6, 1'($urandom), 8'($urandom_range(0, 15) * 4),
                 $urandom,
                 $urandom_range(0, 9) < 7, 1'($urandom), 8'($urandom_range(0, 15) * 4),
                 $urandom, dg, st);
        end

        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, dg, st);
        chk("core_q_drained", 64'(core_q.size()), 64'(0));
        chk("dma_q_drained", 64'(dma_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, meaning data and address width.
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning the maximum number of consecutive cycles a DMA request may be denied.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port core_req  input  1  request from the MEM stage.
REQ-006 SHALL have ports core_we / core_addr / core_wdata  input  1/DWIDTH/DWIDTH  core write enable, address and write data.
REQ-007 SHALL have port core_gnt  output  1  core access performed this cycle.
REQ-008 SHALL have port core_stall  output  1  core_req && !core_gnt; freezes the pipeline.
REQ-009 SHALL have ports dma_req / dma_we / dma_addr / dma_wdata  input  1/1/DWIDTH/DWIDTH  DMA/debug requester.
REQ-010 SHALL have port dma_gnt  output  1  DMA access performed this cycle.
REQ-011 SHALL have ports core_rvalid, dma_rvalid  output  1  registered read-return strobes.
REQ-012 SHALL have ports core_rdata, dma_rdata  output  DWIDTH  registered read data.
REQ-013 SHALL have ports mem_we / mem_addr / mem_wdata  output  1/DWIDTH/DWIDTH  to dmem.
REQ-014 SHALL have port mem_rdata  input  DWIDTH  combinational dmem read data.

Function
REQ-015 SHALL grant at most one requester per cycle; a grant is a single-cycle access with no multi-cycle ownership.
REQ-016 SHALL drive mem_addr, mem_wdata and mem_we combinationally from the granted requester; mem_we SHALL be 0 when no grant is given.
REQ-017 SHALL give the core priority when both requesters are active, except as stated in REQ-022.
REQ-018 SHALL, for a granted read (we=0), assert <req>_rvalid for exactly one cycle in the following cycle, with <req>_rdata holding mem_rdata captured at the grant edge.
REQ-019 SHALL hold rdata stable until the next read return for that requester.
REQ-020 SHALL keep a state machine with states IDLE, CORE, DMA, FORCE_DMA that records the last grant; IDLE applies when there is no request; FORCE_DMA applies when the starvation limit is hit.
REQ-021 SHALL keep a starvation counter that increments each cycle in which dma_req is 1 and dma_gnt is 0, clears on dma_gnt or !dma_req, and saturates at STARVE_MAX.
REQ-022 SHALL grant DMA (stalling the core) in the cycle after the counter reaches STARVE_MAX.
REQ-023 SHALL handle a write and a read from different requesters in consecutive cycles without bubbles.
REQ-024 SHALL NOT deassert core_rvalid when a core read return coincides with a new core_stall.

Reset
REQ-025 SHALL, while rst=1, force FSM=IDLE, counter=0, all gnt/rvalid=0, rdata=0 and mem_we=0.
REQ-026 SHALL discard a read in flight when rst rises; no rvalid follows reset.
REQ-027 SHALL accept a grant in the first cycle after rst falls.

Configuration
REQ-028 SHALL use macro DMEM_ARB_STARVE_EN.
REQ-029 With DMEM_ARB_STARVE_EN defined, SHALL implement REQ-021 and REQ-022.
REQ-030 Without DMEM_ARB_STARVE_EN, SHALL use strict core priority, omit the counter and FORCE_DMA, and let DMA starve indefinitely.

Structure
REQ-031 SHALL place the FSM state enum, the requester ID constants (REQ_CORE=0, REQ_DMA=1) and the STARVE_MAX default in shared package dmem_arb_pkg.
REQ-032 SHALL implement the starvation counter as sub-module arb_starve_cnt (req, gnt, limit_hit); it is instantiated only under DMEM_ARB_STARVE_EN.

Verification
REQ-033 Core only: a core write of addr 0x10, data 0xDEADBEEF, followed by a read of 0x10 -> core_gnt=1 on both cycles, core_rvalid=1 one cycle after the read, and core_rdata=0xDEADBEEF.
REQ-034 DMA only: a DMA read of 0x20 after memory is preloaded with 0x1234 -> dma_gnt the same cycle; dma_rvalid and dma_rdata=0x1234 on the next cycle.
REQ-035 Contention: both requesters active for 10 cycles, STARVE_MAX=4, macro defined -> dma_gnt on cycles 5 and 10 only; core_stall=1 exactly on those cycles.
REQ-036 Contention without the macro: same stimulus -> dma_gnt never asserts and core_stall stays 0.
REQ-037 Reset mid-read: rst asserted in the cycle after a core read grant -> core_rvalid=0, FSM=IDLE and counter=0; the first post-reset request is granted immediately.
REQ-038 Back-to-back mixed traffic: a core write to 0x40 then a DMA read of 0x40 -> the DMA returns the new data with no idle cycle between the two accesses.
